// File: rtl/dma_desc_rr_arbiter_pkg.sv
// Shared definitions for the DMA descriptor/response arbiter.
// The package name is common_cells_pkg because other blocks share it.
// Contents: the response FSM state type, the FSM state width and the
// statistics counter width.
package common_cells_pkg;

    localparam int DMA_ARB_RSP_FSM_WIDTH = 2;
    localparam int DMA_ARB_CNT_W         = 16;

    typedef enum logic [DMA_ARB_RSP_FSM_WIDTH-1:0] {
        IDLE     = 2'd0,
        GRANT    = 2'd1,
        ABORTING = 2'd2
    } dma_arb_rsp_state_e;

endpackage

// File: rtl/dma_desc_rr_pick.sv
// Combinational round-robin picker.
// The scan starts at ptr+1 and wraps modulo NUM_CH. The first requesting
// channel that is not masked wins.
// Ports:
//   req      in   NUM_CH     request vector
//   ptr      in   CH_SEL_W   last served channel; the scan starts one above it
//   mask     in   NUM_CH     channels excluded from this pick
//   pick     out  CH_SEL_W   winning channel index (0 when pick_vld is low)
//   pick_vld out  1          at least one eligible request
module dma_rr_pick
    import common_cells_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CH_SEL_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0]   req,
    input  logic [CH_SEL_W-1:0] ptr,
    input  logic [NUM_CH-1:0]   mask,
    output logic [CH_SEL_W-1:0] pick,
    output logic                pick_vld
);

    logic [NUM_CH-1:0] req_m;
    int                idx;

    always_comb begin
        req_m    = req & ~mask;
        pick     = '0;
        pick_vld = 1'b0;
        idx      = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!pick_vld && req_m[idx]) begin
                pick     = CH_SEL_W'(idx);
                pick_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_desc_rr_arbiter.sv
// N-channel descriptor/response arbiter. It sits between the per-channel DMA
// engines and the shared descriptor queue / response writer.
//
// Descriptor path: a combinational demux. It routes read-ready to the
// selected channel and routes that channel's pop back to the queue.
// Response path: a registered round-robin grant. Aborts are masked per
// channel. An aborted grant waits in a drain state until its abort falls.
//
// Optional feature (macro DMA_ARB_STATS_EN): adds per-channel saturating
// handshake counters, with i_stats_clr and o_grant_cnt ports.
//
// Ports:
//   aclk, areset        clock, asynchronous active-high reset
//   aenable             low blocks new response grants
//   i_abort             per-channel abort level
//   i_desc_ch_sel       channel that owns the current descriptor
//   i_desc_rready       descriptor queue has data
//   o_desc_rd           descriptor pop to the queue
//   o_desc_rready       per-channel descriptor ready
//   i_desc_rd           per-channel descriptor pop
//   o_resp_wr           response valid to the writer
//   o_resp_desc_id      granted response descriptor ID
//   o_resp_ch_sel       granted channel index
//   i_resp_wready       response writer ready
//   i_resp_wr           per-channel response request
//   i_resp_desc_id      per-channel response ID
//   o_resp_wready       per-channel response accept
//   i_stats_clr         (DMA_ARB_STATS_EN) synchronous counter clear
//   o_grant_cnt         (DMA_ARB_STATS_EN) per-channel handshake counts
//
// Response FSM:
//   state    | meaning
//   IDLE     | no grant; arbitrate among the live requests
//   GRANT    | gnt owns the writer; wait for ready or abort
//   ABORTING | gnt was aborted; outputs quiet until its abort drops
module dma_desc_rr_arbiter
    import common_cells_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DESC_ID_W = 8,
    parameter int CH_SEL_W  = $clog2(NUM_CH)
) (
    input  logic                             aclk,
    input  logic                             areset,
    input  logic                             aenable,
    input  logic [NUM_CH-1:0]                i_abort,
    input  logic [CH_SEL_W-1:0]              i_desc_ch_sel,
    input  logic                             i_desc_rready,
    output logic                             o_desc_rd,
    output logic [NUM_CH-1:0]                o_desc_rready,
    input  logic [NUM_CH-1:0]                i_desc_rd,
    output logic                             o_resp_wr,
    output logic [DESC_ID_W-1:0]             o_resp_desc_id,
    output logic [CH_SEL_W-1:0]              o_resp_ch_sel,
    input  logic                             i_resp_wready,
    input  logic [NUM_CH-1:0]                i_resp_wr,
    input  logic [NUM_CH-1:0][DESC_ID_W-1:0] i_resp_desc_id,
    output logic [NUM_CH-1:0]                o_resp_wready
`ifdef DMA_ARB_STATS_EN
    ,
    input  logic                                 i_stats_clr,
    output logic [NUM_CH-1:0][DMA_ARB_CNT_W-1:0] o_grant_cnt
`endif
);

    dma_arb_rsp_state_e  state;
    logic [CH_SEL_W-1:0] gnt;
    logic [CH_SEL_W-1:0] ptr;
    logic [CH_SEL_W-1:0] pick_ptr;
    logic [CH_SEL_W-1:0] pick;
    logic [NUM_CH-1:0]   req;
    logic [NUM_CH-1:0]   pick_mask;
    logic [NUM_CH-1:0]   gnt_oh;
    logic                pick_vld;
    logic                in_grant;
    logic                gnt_abort;
    logic                hs;

    assign req       = i_resp_wr & ~i_abort;
    assign gnt_oh    = {{(NUM_CH-1){1'b0}}, 1'b1} << gnt;
    assign in_grant  = (state == GRANT);
    assign gnt_abort = i_abort[gnt];
    assign hs        = in_grant && i_resp_wready && !gnt_abort;

    // For a back-to-back re-grant, the scan starts above the channel being
    // served and skips that channel. That channel gets its next turn only
    // from IDLE, one cycle later.
    assign pick_ptr  = in_grant ? gnt : ptr;
    assign pick_mask = in_grant ? gnt_oh : '0;

    dma_rr_pick #(
        .NUM_CH   (NUM_CH),
        .CH_SEL_W (CH_SEL_W)
    ) u_pick (
        .req      (req),
        .ptr      (pick_ptr),
        .mask     (pick_mask),
        .pick     (pick),
        .pick_vld (pick_vld)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= CH_SEL_W'(NUM_CH - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (aenable && pick_vld) begin
                        gnt   <= pick;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (gnt_abort) begin
                        state <= ABORTING;
                    end else if (i_resp_wready) begin
                        ptr <= gnt;
                        if (aenable && pick_vld) gnt <= pick;
                        else                     state <= IDLE;
                    end
                end
                ABORTING: begin
                    // ptr is left alone, so the aborted channel keeps its place in the rotation.
                    if (!gnt_abort) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_resp_wr      = in_grant && !gnt_abort;
        o_resp_desc_id = in_grant ? i_resp_desc_id[gnt] : '0;
        o_resp_ch_sel  = in_grant ? gnt : '0;
        o_resp_wready  = hs ? gnt_oh : '0;
    end

    // When the select is out of range, no lane matches and the pop stays low.
    // Reset also holds the demux quiet, so every output is 0 while areset is high.
    always_comb begin
        o_desc_rready = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            o_desc_rready[k] = !areset && i_desc_rready && (i_desc_ch_sel == CH_SEL_W'(k));
        end
        o_desc_rd = |(o_desc_rready & i_desc_rd);
    end

`ifdef DMA_ARB_STATS_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            o_grant_cnt <= '0;
        end else if (i_stats_clr) begin
            o_grant_cnt <= '0;
        end else if (hs && (o_grant_cnt[gnt] != {DMA_ARB_CNT_W{1'b1}})) begin
            o_grant_cnt[gnt] <= o_grant_cnt[gnt] + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dma_desc_rr_arbiter.sv
// Scoreboard bench for dma_desc_rr_arbiter (NUM_CH=4, DESC_ID_W=8).
// Each cycle, the stimulus pushes the expected outputs into a queue, using a
// channel-level reference model. A negedge monitor pops the queue and
// compares the DUT outputs against it. Directed cycles add fixed-value checks.
module tb_dma_desc_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SW = 2;

    logic                 aclk = 1'b0;
    logic                 areset;
    logic                 aenable;
    logic [N-1:0]         i_abort;
    logic [SW-1:0]        i_desc_ch_sel;
    logic                 i_desc_rready;
    logic                 o_desc_rd;
    logic [N-1:0]         o_desc_rready;
    logic [N-1:0]         i_desc_rd;
    logic                 o_resp_wr;
    logic [W-1:0]         o_resp_desc_id;
    logic [SW-1:0]        o_resp_ch_sel;
    logic                 i_resp_wready;
    logic [N-1:0]         i_resp_wr;
    logic [N-1:0][W-1:0]  i_resp_desc_id;
    logic [N-1:0]         o_resp_wready;
`ifdef DMA_ARB_STATS_EN
    logic                 i_stats_clr;
    logic [N-1:0][15:0]   o_grant_cnt;
`endif

    always #5 aclk = ~aclk;

    dma_desc_rr_arbiter #(.NUM_CH(N), .DESC_ID_W(W)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .aenable        (aenable),
        .i_abort        (i_abort),
        .i_desc_ch_sel  (i_desc_ch_sel),
        .i_desc_rready  (i_desc_rready),
        .o_desc_rd      (o_desc_rd),
        .o_desc_rready  (o_desc_rready),
        .i_desc_rd      (i_desc_rd),
        .o_resp_wr      (o_resp_wr),
        .o_resp_desc_id (o_resp_desc_id),
        .o_resp_ch_sel  (o_resp_ch_sel),
        .i_resp_wready  (i_resp_wready),
        .i_resp_wr      (i_resp_wr),
        .i_resp_desc_id (i_resp_desc_id),
        .o_resp_wready  (o_resp_wready)
`ifdef DMA_ARB_STATS_EN
        ,
        .i_stats_clr    (i_stats_clr),
        .o_grant_cnt    (o_grant_cnt)
`endif
    );

    typedef struct {
        logic               wr;
        logic [SW-1:0]      ch;
        logic [W-1:0]       id;
        logic [N-1:0]       wrdy;
        logic [N-1:0]       drr;
        logic               drd;
        logic [N-1:0][15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model, kept at the channel level:
    // owner = channel holding the writer (-1 none), draining = owner was aborted,
    // last = channel served most recently.
    int   m_owner;
    int   m_last;
    bit   m_drain;
    int   m_cnt[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_next(input int from, input int skip, input logic [N-1:0] req);
        for (int d = 1; d <= N; d++) begin
            int c;
            c = (from + d) % N;
            if (req[c] && c != skip) return c;
        end
        return -1;
    endfunction

    task automatic push_model();
        exp_t         e;
        logic [N-1:0] req;
        logic         clr;
        int           n;
        int           s;
        clr = 1'b0;
`ifdef DMA_ARB_STATS_EN
        clr = i_stats_clr;
`endif
        if (areset) begin
            m_owner = -1; m_drain = 0; m_last = N - 1;
            for (int c = 0; c < N; c++) m_cnt[c] = 0;
        end
        req    = i_resp_wr & ~i_abort;
        e.wr   = 1'b0; e.ch = '0; e.id = '0; e.wrdy = '0;
        e.drr  = '0;   e.drd = 1'b0;
        s      = int'(i_desc_ch_sel);
        if (!areset && i_desc_rready && s < N) begin
            e.drr[s] = 1'b1;
            e.drd    = i_desc_rd[s];
        end
        for (int c = 0; c < N; c++) e.cnt[c] = 16'(m_cnt[c]);
        if (!areset && m_owner >= 0 && !m_drain) begin
            e.wr = !i_abort[m_owner];
            e.ch = SW'(m_owner);
            e.id = i_resp_desc_id[m_owner];
            if (i_resp_wready && !i_abort[m_owner]) e.wrdy[m_owner] = 1'b1;
        end
        sb_q.push_back(e);
        if (areset) return;
        if (m_drain) begin
            if (!i_abort[m_owner]) begin m_drain = 0; m_owner = -1; end
        end else if (m_owner >= 0) begin
            if (i_abort[m_owner]) m_drain = 1;
            else if (i_resp_wready) begin
                if (m_cnt[m_owner] < 65535) m_cnt[m_owner]++;
                m_last  = m_owner;
                n       = rr_next(m_owner, m_owner, req);
                m_owner = (aenable && n >= 0) ? n : -1;
            end
        end else if (aenable) begin
            m_owner = rr_next(m_last, -1, req);
        end
        if (clr) for (int c = 0; c < N; c++) m_cnt[c] = 0;
    endtask

    always @(negedge aclk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("resp_wr",     64'(o_resp_wr),      64'(e.wr));
            check("resp_ch_sel", 64'(o_resp_ch_sel),  64'(e.ch));
            check("resp_id",     64'(o_resp_desc_id), 64'(e.id));
            check("resp_wready", 64'(o_resp_wready),  64'(e.wrdy));
            check("desc_rready", 64'(o_desc_rready),  64'(e.drr));
            check("desc_rd",     64'(o_desc_rd),      64'(e.drd));
`ifdef DMA_ARB_STATS_EN
            check("grant_cnt",   64'(o_grant_cnt),    64'(e.cnt));
`endif
        end
    end

    task automatic adv();
        @(posedge aclk); #1;
    endtask

    task automatic step();
        push_model(); adv();
    endtask

    task automatic peek();
        push_model(); @(negedge aclk); #1;
    endtask

    task automatic rst_pulse();
        areset = 1'b1; i_abort = '0; i_resp_wr = '0; i_resp_wready = 1'b0;
`ifdef DMA_ARB_STATS_EN
        i_stats_clr = 1'b0;
`endif
        step();
        areset = 1'b0;
    endtask

    initial begin
        int seq[5];
        seq = '{0, 1, 2, 3, 0};
        areset = 1'b1; aenable = 1'b0; i_abort = '0; i_desc_ch_sel = '0;
        i_desc_rready = 1'b0; i_desc_rd = '0; i_resp_wready = 1'b0; i_resp_wr = '0;
        for (int k = 0; k < N; k++) i_resp_desc_id[k] = 8'h10 + 8'(k);
`ifdef DMA_ARB_STATS_EN
        i_stats_clr = 1'b0;
`endif
        adv();
        step(); step();

        // Round-robin: all four request, writer always ready.
        areset = 1'b0; aenable = 1'b1; i_resp_wr = 4'hF; i_resp_wready = 1'b1;
        peek(); check("idle_after_rst_wr", 64'(o_resp_wr), 64'(0)); adv();
        for (int i = 0; i < 5; i++) begin
            peek();
            check("rr_seq_ch", 64'(o_resp_ch_sel), 64'(seq[i]));
            check("rr_seq_wr", 64'(o_resp_wr), 64'(1));
            adv();
        end

        // Reset while a grant is live: outputs drop in the same cycle.
        areset = 1'b1; i_desc_rready = 1'b1; i_desc_ch_sel = 2'd1;
        peek();
        check("rst_wr",     64'(o_resp_wr),     64'(0));
        check("rst_wrdy",   64'(o_resp_wready), 64'(0));
        check("rst_drr",    64'(o_desc_rready), 64'(0));
        adv();
        areset = 1'b0; i_desc_rready = 1'b0; i_resp_wready = 1'b0;
        step();
        peek(); check("first_after_rst_ch", 64'(o_resp_ch_sel), 64'(0));
        check("first_after_rst_wr", 64'(o_resp_wr), 64'(1)); adv();

        // Backpressure on ch2.
        rst_pulse();
        i_resp_wr = 4'b0100; i_resp_desc_id[2] = 8'hA5; i_resp_wready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            peek();
            check("bp_wr",   64'(o_resp_wr),      64'(1));
            check("bp_id",   64'(o_resp_desc_id), 64'(8'hA5));
            check("bp_ch",   64'(o_resp_ch_sel),  64'(2));
            check("bp_wrdy", 64'(o_resp_wready),  64'(0));
            adv();
        end
        i_resp_wready = 1'b1;
        peek(); check("bp_hs_wrdy", 64'(o_resp_wready), 64'(4'b0100)); adv();

        // Abort on ch1: no handshake, drain, and ch1 keeps its turn.
        rst_pulse();
        i_resp_wr = 4'b0001; i_resp_wready = 1'b1;
        step(); step();
        i_resp_wr = 4'b0010; i_resp_wready = 1'b0;
        step();
        i_abort = 4'b0010; i_resp_wready = 1'b1;
        peek();
        check("ab_wr",   64'(o_resp_wr),     64'(0));
        check("ab_wrdy", 64'(o_resp_wready), 64'(0));
        adv();
        peek();
        check("ab_drain_wr", 64'(o_resp_wr),      64'(0));
        check("ab_drain_id", 64'(o_resp_desc_id), 64'(0));
        adv();
        i_abort = '0; i_resp_wr = 4'b0011; i_resp_wready = 1'b0;
        step(); step();
        peek(); check("ab_rr_ch", 64'(o_resp_ch_sel), 64'(1));
        check("ab_rr_wr", 64'(o_resp_wr), 64'(1)); adv();

        // Descriptor demux.
        i_desc_ch_sel = 2'd3; i_desc_rready = 1'b1; i_desc_rd = 4'b1000;
        peek();
        check("desc_rr_sel3", 64'(o_desc_rready), 64'(4'b1000));
        check("desc_rd_sel3", 64'(o_desc_rd),     64'(1));
        adv();
        i_desc_rd = 4'b0001;
        peek(); check("desc_rd_other", 64'(o_desc_rd), 64'(0)); adv();
        i_desc_rready = 1'b0;

`ifdef DMA_ARB_STATS_EN
        rst_pulse();
        i_resp_wr = 4'b0001; i_resp_wready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        peek(); check("stats_cnt3", 64'(o_grant_cnt[0]), 64'(3)); adv();
        i_stats_clr = 1'b1;
        peek(); check("stats_clr_hs", 64'(o_resp_wready), 64'(4'b0001)); adv();
        i_stats_clr = 1'b0;
        peek(); check("stats_cleared", 64'(o_grant_cnt[0]), 64'(0)); adv();
`endif

        // Randomized traffic.
        rst_pulse();
        for (int i = 0; i < 600; i++) begin
            areset        = ($urandom_range(0, 199) == 0);
            aenable       = ($urandom_range(0, 7) != 0);
            i_resp_wr     = 4'($urandom);
            i_resp_wready = ($urandom_range(0, 9) < 7);
            i_desc_rready = 1'($urandom);
            i_desc_ch_sel = 2'($urandom);
            i_desc_rd     = 4'($urandom);
            for (int k = 0; k < N; k++) begin
                i_abort[k]        = ($urandom_range(0, 11) == 0);
                i_resp_desc_id[k] = 8'($urandom);
            end
`ifdef DMA_ARB_STATS_EN
            i_stats_clr = ($urandom_range(0, 31) == 0);
`endif
            step();
        end

        areset = 1'b0; i_resp_wr = '0; i_abort = '0;
        step();
        @(negedge aclk); #1;
        check("sb_drained", 64'(sb_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
